// File: rtl/input_assembler_if.sv
// Bundles the beat-input and sample-output signals of input_assembler.
// Ports: in_valid, Xin6..Xin0, clear, out_ready (toward the assembler);
//        out_valid, out_data, out_label, label_err, overflow, sample_count (from it).
interface input_assembler_if #(
  parameter int NIBBLES = 8,
  parameter int CNT_W   = 16
);

  // Beat side: one 4-bit data nibble plus a 3-bit label per cycle, no stall.
  logic                   in_valid;
  logic                   Xin6;
  logic                   Xin5;
  logic                   Xin4;
  logic                   Xin3;
  logic                   Xin2;
  logic                   Xin1;
  logic                   Xin0;
  logic                   clear;

  // Sample side: valid/ready handshake on the assembled word.
  logic                   out_ready;
  logic                   out_valid;
  logic [4*NIBBLES-1:0]   out_data;
  logic [2:0]             out_label;
  logic                   label_err;
  logic                   overflow;
  logic [CNT_W-1:0]       sample_count;

  // Environment side: produces beats, consumes samples.
  modport master (
    output in_valid, Xin6, Xin5, Xin4, Xin3, Xin2, Xin1, Xin0, clear, out_ready,
    input  out_valid, out_data, out_label, label_err, overflow, sample_count
  );

  // Assembler side.
  modport slave (
    input  in_valid, Xin6, Xin5, Xin4, Xin3, Xin2, Xin1, Xin0, clear, out_ready,
    output out_valid, out_data, out_label, label_err, overflow, sample_count
  );

endinterface

// File: rtl/input_assembler.sv
// Purpose: gathers NIBBLES 4-bit beats (beat 0 in the LSBs) into one labelled sample.
// Latency: sample visible on out_valid one cycle after its last beat is accepted.
// Backpressure: none toward the beat source; a sample completing while the output
//               register is held (out_valid=1, out_ready=0) is dropped and overflow sticks.
// Ports: clk, reset (async, active-low), bus (input_assembler_if.slave):
//   in_valid/Xin6..Xin3 (data)/Xin2..Xin0 (label)/clear in; out_ready in;
//   out_valid/out_data/out_label/label_err/overflow/sample_count out.
module input_assembler #(
  parameter int NIBBLES = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input_assembler_if.slave  bus
);

  localparam int DW    = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic {
    IDLE,     // waiting for beat 0
    COLLECT   // beats 1..NIBBLES-1
  } state_t;

  // Collector state
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DW-1:0]      asm_q, asm_d;
  logic [2:0]         label_q, label_d;
  logic               mis_q, mis_d;

  // Output register
  logic               out_vld_q, out_vld_d;
  logic [DW-1:0]      out_dat_q;
  logic [2:0]         out_lbl_q;
  logic               out_err_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;

  // Per-cycle beat decode
  logic [3:0]         beat_data;
  logic [2:0]         beat_label;
  logic [DW-1:0]      asm_ins;
  logic [2:0]         smp_label;
  logic               smp_mis;
  logic               complete;
  logic               load;
  logic               drop;

  assign beat_data  = {bus.Xin6, bus.Xin5, bus.Xin4, bus.Xin3};
  assign beat_label = {bus.Xin2, bus.Xin1, bus.Xin0};

  // ------------------------------------------------------------------
  // Collector FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      label_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      label_q <= label_d;
      mis_q   <= mis_d;
    end
  end

  // ------------------------------------------------------------------
  // Collector FSM: next state, partial sample and completion strobe
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    label_d   = label_q;
    mis_d     = mis_q;
    smp_label = label_q;
    smp_mis   = mis_q;
    complete  = 1'b0;

    // Partial word with the current beat dropped into its slot; this is
    // also the finished sample when the current beat is the last one.
    // In IDLE idx_q is 0 and asm_q is 0, so beat 0 lands in the LSBs.
    asm_ins = asm_q;
    asm_ins[4*idx_q +: 4] = beat_data;

    if (bus.clear) begin
      // Clear beats a coincident in_valid: the beat is discarded with the partial sample.
      state_d = IDLE;
      idx_d   = '0;
      asm_d   = '0;
      label_d = '0;
      mis_d   = 1'b0;
    end else if (bus.in_valid) begin
      unique case (state_q)
        IDLE: begin
          // Beat 0 defines the label; it cannot mismatch itself.
          smp_label = beat_label;
          smp_mis   = 1'b0;
          if (NIBBLES == 1) begin
            // Single-beat samples complete immediately and never leave IDLE.
            complete = 1'b1;
            asm_d    = '0;
          end else begin
            state_d = COLLECT;
            idx_d   = IDX_W'(1);
            asm_d   = asm_ins;
            label_d = beat_label;
            mis_d   = 1'b0;
          end
        end

        COLLECT: begin
          smp_mis = mis_q | (beat_label != label_q);
          if (idx_q == LAST_IDX) begin
            complete = 1'b1;
            state_d  = IDLE;
            idx_d    = '0;
            asm_d    = '0;
            label_d  = '0;
            mis_d    = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            asm_d = asm_ins;
            mis_d = smp_mis;
          end
        end

        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Output register control
  // ------------------------------------------------------------------
  // A finished sample may enter the output register if it is empty or is
  // being emptied this same cycle; otherwise it has nowhere to go.
  assign load = complete & (~out_vld_q | bus.out_ready);
  assign drop = complete & out_vld_q & ~bus.out_ready;

  always_comb begin
    out_vld_d = out_vld_q;
    if (load) begin
      out_vld_d = 1'b1;
    end else if (out_vld_q && bus.out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_lbl_q <= '0;
      out_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      // Contents only change on load, so a held sample stays stable and
      // the last sample remains readable after it drains.
      if (load) begin
        out_dat_q <= asm_ins;
        out_lbl_q <= smp_label;
        out_err_q <= smp_mis;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
      // Saturating load counter.
      if (load && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid    = out_vld_q;
  assign bus.out_data     = out_dat_q;
  assign bus.out_label    = out_lbl_q;
  assign bus.label_err    = out_err_q;
  assign bus.overflow     = ovf_q;
  assign bus.sample_count = cnt_q;

endmodule

// File: tb/tb_input_assembler.sv
// Directed bench for input_assembler (NIBBLES=8 main instance, NIBBLES=1 side instance).
module tb_input_assembler;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  input_assembler_if #(.NIBBLES(8), .CNT_W(16)) bus ();
  input_assembler_if #(.NIBBLES(1), .CNT_W(16)) bus1 ();

  input_assembler #(.NIBBLES(8), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  input_assembler #(.NIBBLES(1), .CNT_W(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [2:0] l);
    bus.in_valid = v;
    {bus.Xin6, bus.Xin5, bus.Xin4, bus.Xin3} = d;
    {bus.Xin2, bus.Xin1, bus.Xin0} = l;
  endtask

  // One accepted beat on the main instance.
  task automatic send(input logic [3:0] d, input logic [2:0] l);
    drive(1'b1, d, l);
    @(posedge clk); #1;
    drive(1'b0, 4'h5, 3'b000);
  endtask

  // Idle cycles with junk on the data lines.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 4'h9, 3'b010);
      @(posedge clk); #1;
    end
  endtask

  task automatic send1(input logic [3:0] d, input logic [2:0] l);
    bus1.in_valid = 1'b1;
    {bus1.Xin6, bus1.Xin5, bus1.Xin4, bus1.Xin3} = d;
    {bus1.Xin2, bus1.Xin1, bus1.Xin0} = l;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] post[8];
    int         gaps[8];
    total  = 0;
    passed = 0;
    reset  = 1'b0;
    drive(1'b0, 4'h0, 3'b000);
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0;
    {bus1.Xin6, bus1.Xin5, bus1.Xin4, bus1.Xin3, bus1.Xin2, bus1.Xin1, bus1.Xin0} = 7'h0;
    bus1.clear     = 1'b0;
    bus1.out_ready = 1'b1;

    // ---- reset state ----
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_label", bus.out_label, 0);
    chk("rst_label_err", bus.label_err, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_count", bus.sample_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // ---- NIBBLES=1: every beat is a sample ----
    send1(4'hA, 3'b011);
    chk("n1_valid", bus1.out_valid, 1);
    chk("n1_data0", bus1.out_data, 4'hA);
    chk("n1_label0", bus1.out_label, 3'b011);
    send1(4'h5, 3'b001);
    chk("n1_data1", bus1.out_data, 4'h5);
    chk("n1_label1", bus1.out_label, 3'b001);
    chk("n1_count", bus1.sample_count, 2);

    // ---- basic ----
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) send(4'(k), 3'b101);
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_data", bus.out_data, 32'h87654321);
    chk("basic_label", bus.out_label, 5);
    chk("basic_err", bus.label_err, 0);
    chk("basic_count", bus.sample_count, 1);
    gap(1);
    chk("basic_drain", bus.out_valid, 0);

    // ---- label mismatch on beat 4 ----
    for (int k = 1; k <= 8; k++) send(4'(k), (k == 4) ? 3'b100 : 3'b101);
    chk("mis_data", bus.out_data, 32'h87654321);
    chk("mis_label", bus.out_label, 5);
    chk("mis_err", bus.label_err, 1);
    chk("mis_count", bus.sample_count, 2);
    gap(1);

    // ---- back-to-back: ready only on sample 2's completion cycle ----
    pulse_reset();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) send(4'(k), 3'b000);
    chk("b2b_a_valid", bus.out_valid, 1);
    chk("b2b_a_data", bus.out_data, 32'h87654321);
    for (int k = 8; k >= 2; k--) send(4'(k), 3'b110);
    chk("b2b_a_held", bus.out_data, 32'h87654321);
    bus.out_ready = 1'b1;
    send(4'h1, 3'b110);
    bus.out_ready = 1'b0;
    chk("b2b_b_valid", bus.out_valid, 1);
    chk("b2b_b_data", bus.out_data, 32'h12345678);
    chk("b2b_b_label", bus.out_label, 6);
    chk("b2b_b_err", bus.label_err, 0);
    chk("b2b_overflow", bus.overflow, 0);
    chk("b2b_count", bus.sample_count, 2);
    gap(2);
    chk("b2b_stable", bus.out_data, 32'h12345678);
    bus.out_ready = 1'b1;
    gap(1);
    chk("b2b_drain", bus.out_valid, 0);

    // ---- clear with coincident beat, then gapped sample ----
    send(4'hF, 3'b111);
    send(4'hE, 3'b111);
    send(4'hD, 3'b111);
    drive(1'b1, 4'hF, 3'b111);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    drive(1'b0, 4'h5, 3'b000);
    chk("clr_keeps_data", bus.out_data, 32'h12345678);
    chk("clr_keeps_count", bus.sample_count, 2);
    post = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
    gaps = '{0, 2, 1, 0, 3, 0, 1, 0};
    for (int k = 0; k < 7; k++) begin
      gap(gaps[k]);
      send(post[k], 3'b011);
    end
    chk("clr_not_early", bus.out_valid, 0);
    gap(gaps[7]);
    send(post[7], 3'b011);
    chk("clr_valid", bus.out_valid, 1);
    chk("clr_data", bus.out_data, 32'h21FEDCBA);
    chk("clr_label", bus.out_label, 3);
    chk("clr_err", bus.label_err, 0);
    chk("clr_count", bus.sample_count, 3);
    gap(1);

    // ---- overflow ----
    pulse_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(4'(k), 3'b010);
    chk("ovf_first_data", bus.out_data, 32'h76543210);
    chk("ovf_first_flag", bus.overflow, 0);
    for (int k = 8; k < 16; k++) send(4'(k), 3'b010);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_held_valid", bus.out_valid, 1);
    chk("ovf_held_data", bus.out_data, 32'h76543210);
    chk("ovf_count", bus.sample_count, 1);
    bus.out_ready = 1'b1;
    gap(1);
    chk("ovf_drain", bus.out_valid, 0);
    chk("ovf_sticky", bus.overflow, 1);

    // ---- reset mid-sample ----
    for (int k = 1; k <= 5; k++) send(4'(k), 3'b001);
    reset = 1'b0;
    #1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_data", bus.out_data, 0);
    chk("mrst_overflow", bus.overflow, 0);
    chk("mrst_count", bus.sample_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    send(4'h3, 3'b100); send(4'h1, 3'b100); send(4'h4, 3'b100); send(4'h1, 3'b100);
    send(4'h5, 3'b100); send(4'h9, 3'b100); send(4'h2, 3'b100); send(4'h6, 3'b100);
    chk("mrst_after_valid", bus.out_valid, 1);
    chk("mrst_after_data", bus.out_data, 32'h62951413);
    chk("mrst_after_label", bus.out_label, 4);
    chk("mrst_after_count", bus.sample_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
